// File: rtl/sound_pwm_mixer.sv
// Timer-3 PWM speaker level, windowed into signed 16-bit samples with volume scaling.
// Optional box averaging over the window is enabled by defining SOUND_FILTER_EN.
module sound_pwm_mixer #(
    parameter int SAMPLE_DIV = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_run,
    input  logic        timer_tick,
    input  logic [15:0] timer_preset,
    input  logic [15:0] timer_pivot,
    input  logic [2:0]  sound_control,
    input  logic [2:0]  sound_volume,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun
);
    localparam int DATA_W = 16;
    localparam int WIN_W  = $clog2(SAMPLE_DIV);
    localparam int ONES_W = WIN_W + 1;
    localparam int SHIFT  = 14 - WIN_W;

    logic [15:0]        counter_p0;
    logic [WIN_W-1:0]   window_p0;
    logic               level;
    logic               win_end;
    logic [ONES_W-1:0]  ones;
    logic               load;
    logic               drop;
    logic signed [DATA_W-1:0] sample_p1;
    logic               vld_p1;
    logic               overrun_p1;
    logic               unused_ok;

    function automatic logic signed [DATA_W-1:0] scale_sample(
        input logic [ONES_W-1:0] ones_in,
        input logic [1:0]        vol,
        input logic [1:0]        ctl
    );
        logic signed [DATA_W-1:0] centered;
        centered = $signed({{(DATA_W-ONES_W-1){1'b0}}, ones_in, 1'b0})
                 - $signed(DATA_W'(SAMPLE_DIV));
        if (ctl != 2'd0 || vol == 2'd0)
            return '0;
        else if (vol == 2'd3)
            return centered <<< SHIFT;
        else
            return centered <<< (SHIFT - 1);
    endfunction

    // Stage p0: timer down-counter, window position, PWM level
    always_ff @(posedge clk) begin
        if (reset)
            counter_p0 <= 16'd0;
        else if (!timer_run)
            counter_p0 <= timer_preset;
        else if (timer_tick)
            counter_p0 <= (counter_p0 == 16'd0) ? timer_preset : counter_p0 - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            window_p0 <= '0;
        else
            window_p0 <= window_p0 + WIN_W'(1);
    end

    assign level   = timer_run && (counter_p0 <= timer_pivot);
    assign win_end = (window_p0 == WIN_W'(SAMPLE_DIV - 1));

`ifdef SOUND_FILTER_EN
    logic [ONES_W-1:0] acc_p0;

    always_ff @(posedge clk) begin
        if (reset || win_end)
            acc_p0 <= '0;
        else
            acc_p0 <= acc_p0 + ONES_W'(level);
    end

    assign ones = acc_p0 + ONES_W'(level);
`else
    assign ones = level ? ONES_W'(SAMPLE_DIV) : '0;
`endif

    // Stage p1: sample register with valid/ready hold and overrun detect
    assign load = win_end && (!vld_p1 || sample_ready);
    assign drop = win_end && vld_p1 && !sample_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_p1  <= '0;
            vld_p1     <= 1'b0;
            overrun_p1 <= 1'b0;
        end else begin
            overrun_p1 <= drop;
            if (load) begin
                sample_p1 <= scale_sample(ones, sound_volume[1:0], sound_control[1:0]);
                vld_p1    <= 1'b1;
            end else if (vld_p1 && sample_ready) begin
                vld_p1    <= 1'b0;
            end
        end
    end

    assign sample_out   = sample_p1;
    assign sample_valid = vld_p1;
    assign overrun      = overrun_p1;
    assign unused_ok    = ^{sound_control[2], sound_volume[2]};
endmodule

// File: tb/tb_sound_pwm_mixer.sv
// Directed bench for sound_pwm_mixer at SAMPLE_DIV=128; expectations follow SOUND_FILTER_EN.
module tb_sound_pwm_mixer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        timer_run = 1'b0;
    logic        timer_tick = 1'b1;
    logic [15:0] timer_preset = 16'd3;
    logic [15:0] timer_pivot = 16'd2;
    logic [2:0]  sound_control = 3'd0;
    logic [2:0]  sound_volume = 3'd3;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        overrun;

    int checks = 0;
    int errors = 0;

`ifdef SOUND_FILTER_EN
    localparam logic [15:0] EXP_PV2 = 16'h2000;
    localparam logic [15:0] EXP_PV1 = 16'h0000;
    localparam logic [15:0] EXP_PV0 = 16'hE000;
`else
    localparam logic [15:0] EXP_PV2 = 16'h4000;
    localparam logic [15:0] EXP_PV1 = 16'h4000;
    localparam logic [15:0] EXP_PV0 = 16'hC000;
`endif

    sound_pwm_mixer #(.SAMPLE_DIV(128)) dut (
        .clk           (clk),
        .reset         (reset),
        .timer_run     (timer_run),
        .timer_tick    (timer_tick),
        .timer_preset  (timer_preset),
        .timer_pivot   (timer_pivot),
        .sound_control (sound_control),
        .sound_volume  (sound_volume),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic window_test(input string tag, input logic [15:0] preset,
                               input logic [15:0] pivot, input logic run,
                               input logic [2:0] vol, input logic [2:0] ctl,
                               input logic [15:0] exp);
        timer_preset  = preset;
        timer_pivot   = pivot;
        timer_run     = run;
        sound_volume  = vol;
        sound_control = ctl;
        sample_ready  = 1'b1;
        apply_reset();
        cycles(127);
        check({tag, "_early"}, 16'(sample_valid), 16'd0);
        cycles(1);
        check({tag, "_vld"}, 16'(sample_valid), 16'd1);
        check({tag, "_out"}, sample_out, exp);
        cycles(1);
        check({tag, "_drain"}, 16'(sample_valid), 16'd0);
    endtask

    initial begin
        cycles(3);
        check("rst_out", sample_out, 16'h0000);
        check("rst_vld", 16'(sample_valid), 16'd0);
        check("rst_ovr", 16'(overrun), 16'd0);

        window_test("pv2",      16'd3, 16'd2,    1'b1, 3'd3, 3'd0, EXP_PV2);
        window_test("pv1",      16'd3, 16'd1,    1'b1, 3'd3, 3'd0, EXP_PV1);
        window_test("pv0",      16'd3, 16'd0,    1'b1, 3'd3, 3'd0, EXP_PV0);
        window_test("pvmax",    16'd3, 16'hFFFF, 1'b1, 3'd3, 3'd0, 16'h4000);
        window_test("run0_v3",  16'd3, 16'd2,    1'b0, 3'd3, 3'd0, 16'hC000);
        window_test("run0_v1",  16'd3, 16'd2,    1'b0, 3'd1, 3'd0, 16'hE000);
        window_test("run0_v2",  16'd3, 16'd2,    1'b0, 3'd2, 3'd0, 16'hE000);
        window_test("run0_v0",  16'd3, 16'd2,    1'b0, 3'd0, 3'd0, 16'h0000);
        window_test("run0_c1",  16'd3, 16'd2,    1'b0, 3'd3, 3'd1, 16'h0000);
        window_test("run0_v7c4",16'd3, 16'd2,    1'b0, 3'd7, 3'd4, 16'hC000);
        window_test("run1_c2",  16'd3, 16'hFFFF, 1'b1, 3'd3, 3'd2, 16'h0000);

        // Back-pressure: first sample held, second dropped with an overrun pulse
        timer_run     = 1'b0;
        sound_volume  = 3'd3;
        sound_control = 3'd0;
        sample_ready  = 1'b0;
        apply_reset();
        cycles(127);
        check("bp_early", 16'(sample_valid), 16'd0);
        cycles(1);
        check("bp_vld128", 16'(sample_valid), 16'd1);
        check("bp_out128", sample_out, 16'hC000);
        check("bp_ovr128", 16'(overrun), 16'd0);
        sound_volume = 3'd0;
        cycles(127);
        check("bp_ovr255", 16'(overrun), 16'd0);
        check("bp_out255", sample_out, 16'hC000);
        cycles(1);
        check("bp_ovr256", 16'(overrun), 16'd1);
        check("bp_out256", sample_out, 16'hC000);
        check("bp_vld256", 16'(sample_valid), 16'd1);
        cycles(1);
        check("bp_ovr257", 16'(overrun), 16'd0);
        sample_ready = 1'b1;
        check("bp_pull_out", sample_out, 16'hC000);
        cycles(1);
        check("bp_pull_vld", 16'(sample_valid), 16'd0);

        // Reset mid-window clears outputs and restarts window timing
        sound_volume = 3'd3;
        sample_ready = 1'b0;
        apply_reset();
        cycles(128 + 60);
        check("mid_vld_pre", 16'(sample_valid), 16'd1);
        check("mid_out_pre", sample_out, 16'hC000);
        reset = 1'b1;
        cycles(1);
        check("mid_rst_out", sample_out, 16'h0000);
        check("mid_rst_vld", 16'(sample_valid), 16'd0);
        check("mid_rst_ovr", 16'(overrun), 16'd0);
        reset = 1'b0;
        cycles(127);
        check("mid_early", 16'(sample_valid), 16'd0);
        cycles(1);
        check("mid_vld", 16'(sample_valid), 16'd1);
        check("mid_out", sample_out, 16'hC000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
